// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
package counter_pkg;

  localparam int DEF_MODULUS = 10;
  localparam int DEF_WIDTH   = 4;

  // Ceiling log2: bits needed to hold values 0..value-1.
  function automatic int clog2(input int unsigned value);
    int          r;
    int unsigned v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_modn.sv
// Cascadable up/down modulo-N counter with clear, checked parallel load,
// terminal-count/carry outputs, a wrap pulse and a sticky bad-load flag.
module counter_modn
  import counter_pkg::*;
#(
  parameter int MODULUS = DEF_MODULUS,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             ena,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cnt,
  output logic             max,
  output logic             cout,
  output logic             wrap,
  output logic             err
);

  if (MODULUS < 2 || MODULUS > 65536) begin : g_bad_modulus
    $error("counter_modn: MODULUS must be in 2..65536");
  end
  if (WIDTH < clog2(MODULUS)) begin : g_bad_width
    $error("counter_modn: WIDTH too small for MODULUS");
  end

  // Terminal value held one bit wider so it compares cleanly against
  // extended arithmetic, including power-of-two moduli.
  localparam logic [WIDTH:0] TOP_V = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;
  logic           at_top;
  logic           at_zero;
  logic           up_wraps;
  logic           dn_wraps;
  logic           din_ok;

  assign cnt_ext  = {1'b0, cnt_q};
  assign inc_ext  = cnt_ext + 1'b1;
  assign dec_ext  = cnt_ext - 1'b1;
  assign at_top   = (cnt_ext == TOP_V);
  assign at_zero  = (cnt_q == '0);
  // Wrap detection uses the extra bit: past the top going up, borrow going down.
  assign up_wraps = (inc_ext > TOP_V);
  assign dn_wraps = dec_ext[WIDTH];
  assign din_ok   = ({1'b0, din} <= TOP_V);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (clr) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (load) begin
      if (din_ok) begin
        cnt_d = din;
      end else begin
        err_d = 1'b1;
      end
    end else if (ena) begin
      if (up) begin
        if (up_wraps) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (dn_wraps) begin
          cnt_d  = TOP_V[WIDTH-1:0];
          wrap_d = 1'b1;
        end else begin
          cnt_d = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign err  = err_q;
  assign max  = up ? at_top : at_zero;
  assign cout = max & ena & ~clr & ~load;

endmodule

// File: doc/counter_modn.md
COUNTER_MODN -- requirements
Module: counter_modn

Interface
REQ-001 Parameter MODULUS, default 10, count range 0..MODULUS-1; legal values 2..65536.
REQ-002 Parameter WIDTH, default 4, counter width; SHALL be at least clog2(MODULUS), elaboration error otherwise.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 res  input  1  asynchronous, active-high reset.
REQ-005 ena  input  1  count enable / carry-in from lower stage.
REQ-006 up  input  1  direction; 1 = count up, 0 = count down.
REQ-007 clr  input  1  synchronous clear.
REQ-008 load  input  1  synchronous parallel load.
REQ-009 din  input  WIDTH  load value.
REQ-010 cnt  output  WIDTH  registered count value.
REQ-011 max  output  1  combinational terminal-count flag for current direction.
REQ-012 cout  output  1  combinational carry/borrow-out for cascading.
REQ-013 wrap  output  1  registered one-cycle pulse after a wrap.
REQ-014 err  output  1  registered sticky flag: out-of-range load attempted.

Function
REQ-015 Per-edge priority SHALL be: clr > load > ena > hold.
REQ-016 clr=1: cnt <= 0, err <= 0, wrap <= 0.
REQ-017 load=1, din < MODULUS: cnt <= din; wrap <= 0; err unchanged.
REQ-018 load=1, din >= MODULUS: cnt unchanged, err <= 1, wrap <= 0.
REQ-019 ena=1, up=1: cnt < MODULUS-1 -> cnt+1; cnt = MODULUS-1 -> 0, wrap <= 1.
REQ-020 ena=1, up=0: cnt > 0 -> cnt-1; cnt = 0 -> MODULUS-1, wrap <= 1.
REQ-021 Otherwise cnt holds and wrap <= 0; wrap SHALL never be high two consecutive cycles unless a wrap occurs on each edge.
REQ-022 max = (up & cnt==MODULUS-1) | (~up & cnt==0); follows up combinationally.
REQ-023 cout = max & ena & ~clr & ~load; high exactly in cycles where the next edge wraps.
REQ-024 Increment/decrement SHALL be computed at WIDTH+1 bits; cnt SHALL never hold a value >= MODULUS.
REQ-025 Direction change mid-count SHALL take effect on the next enabled edge with no skipped or repeated value.
REQ-026 MODULUS a power of two SHALL behave identically (explicit compare, not natural overflow).
REQ-027 Latency: cnt, wrap, err update one edge after qualifying inputs; max/cout zero latency.

Reset
REQ-028 res=1 SHALL immediately force cnt=0, wrap=0, err=0 independent of clk.
REQ-029 Reset mid-count SHALL abandon the count; first enabled edge after release yields 1 (up) or MODULUS-1 (down).
REQ-030 Outputs max/cout after reset SHALL reflect cnt=0 and current up/ena.

Structure
REQ-031 Shared package counter_pkg SHALL hold clog2 function and default constants (DEF_MODULUS=10, DEF_WIDTH=4).
REQ-032 Single module, no sub-modules; multi-digit counters are built by chaining cout into the next stage ena outside this block.

Verification
REQ-033 Defaults, up=1, ena=1 from reset, 12 edges -> cnt 1..9,0,1,2; wrap high only the cycle after the 9->0 edge; cout high while cnt=9.
REQ-034 up=0, ena=1 from reset -> cnt 9,8,...,0,9; max high at cnt=0; wrap after 0->9.
REQ-035 load=1 din=7 -> cnt=7, err=0; load=1 din=12 -> cnt stays 7, err=1 and sticky; clr=1 -> cnt=0, err=0.
REQ-036 clr=1, load=1, ena=1 same edge -> cnt=0 (clr wins); load=1, ena=1, din=3 -> cnt=3.
REQ-037 Two instances, MODULUS=10 and 6, cout of first drives ena of second -> second increments once per 10 edges, both wrap 59->00 on edge 60.
REQ-038 res pulsed between edges at cnt=5 -> cnt=0 immediately; MODULUS=16 WIDTH=4 run -> 15->0 wrap with wrap pulse.
